conv_window_sched: RTL and testbench

//  Frame-level scheduler for a single-cycle 3x3 convolution datapath (27 x ACT_W-bit taps in, 1-cycle registered latency, valid->ready).

---
 rtl/conv_window_sched.sv | 140 ++++++++++++++
 tb/tb_conv_window_sched.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_sched.sv
// Raster-scan 3x3xCH window scheduler for a single-cycle convolution datapath.
// Two pixel line buffers feed a 3x3 shift window; one window per valid output position.
module conv_window_sched #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int ACT_W = 16,
  parameter int CH    = 3
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start_i,
  input  logic                    in_valid_i,
  input  logic [CH*ACT_W-1:0]     in_data_i,
  output logic                    in_ready_o,
  output logic                    win_valid_o,
  output logic [9*CH*ACT_W-1:0]   win_data_o,
  input  logic                    conv_ready_i,
  output logic                    busy_o,
  output logic                    frame_done_o,
  output logic [15:0]             out_count_o
);

  localparam int PW = CH * ACT_W;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [15:0] N_RES = 16'((IMG_H - 2) * (IMG_W - 2));

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      col_q, col_d;
  logic [RW-1:0]      row_q, row_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               win_valid_q, win_valid_d;
  logic [9*PW-1:0]    win_data_q, win_data_d;
  logic [PW-1:0]      lb0_q [IMG_W];
  logic [PW-1:0]      lb1_q [IMG_W];
  logic [PW-1:0]      wnd_q [3][3];
  logic [PW-1:0]      wnd_sh [3][3];
  logic               accept, last_pix, issue;

  assign in_ready_o   = (state_q == S_RUN);
  assign busy_o       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign frame_done_o = (state_q == S_DONE);
  assign win_valid_o  = win_valid_q;
  assign win_data_o   = win_data_q;
  assign out_count_o  = cnt_q;

  assign accept   = in_valid_i && in_ready_o;
  assign last_pix = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
  // Columns 0/1 of a row still hold the previous row's tail, so they never issue.
  assign issue    = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      wnd_sh[r][0] = wnd_q[r][1];
      wnd_sh[r][1] = wnd_q[r][2];
    end
    wnd_sh[0][2] = lb0_q[IMG_W-1];
    wnd_sh[1][2] = lb1_q[IMG_W-1];
    wnd_sh[2][2] = in_data_i;

    win_valid_d = issue;
    win_data_d  = win_data_q;
    if (issue) begin
      for (int k = 0; k < CH; k++)
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            win_data_d[(k*9 + 3*r + c)*ACT_W +: ACT_W] = wnd_sh[r][c][k*ACT_W +: ACT_W];
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;

    if (busy_o && conv_ready_i) cnt_d = cnt_q + 16'd1;

    if (accept) begin
      if (col_q == CW'(IMG_W - 1)) begin
        col_d = '0;
        if (row_q != RW'(IMG_H - 1)) row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          row_d   = '0;
          col_d   = '0;
          cnt_d   = '0;
        end
      end
      S_RUN:   if (accept && last_pix) state_d = S_DRAIN;
      S_DRAIN: if (cnt_d == N_RES)     state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      cnt_q       <= '0;
      win_valid_q <= 1'b0;
      win_data_q  <= '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          wnd_q[r][c] <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      win_valid_q <= win_valid_d;
      win_data_q  <= win_data_d;
      if (accept) wnd_q <= wnd_sh;
    end
  end

  // Line buffers are fully refilled before row 2 of any frame, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0_q[0] <= lb1_q[IMG_W-1];
      lb1_q[0] <= in_data_i;
      for (int i = 1; i < IMG_W; i++) begin
        lb0_q[i] <= lb0_q[i-1];
        lb1_q[i] <= lb1_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_conv_window_sched.sv
// Bench for conv_window_sched: 4x4 smoke instance plus an 8x8 instance checked every
// cycle against a position-based window model.
module tb_conv_window_sched;
  localparam int ACT_W = 16;
  localparam int CH    = 3;
  localparam int PW    = CH * ACT_W;
  localparam int WW    = 9 * PW;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  int n_cmp = 0;
  int n_fail = 0;

  // 8x8 instance
  logic start, in_valid, cr_inj, cr_q;
  logic [PW-1:0] in_data;
  logic in_ready, win_valid, busy, frame_done;
  logic [WW-1:0] win_data;
  logic [15:0] out_count;
  logic conv_ready;
  assign conv_ready = cr_q | cr_inj;

  // 4x4 instance
  logic s_start, s_in_valid, s_cr_q;
  logic [PW-1:0] s_in_data;
  logic s_in_ready, s_win_valid, s_busy, s_frame_done;
  logic [WW-1:0] s_win_data;
  logic [15:0] s_out_count;

  conv_window_sched #(.IMG_W(8), .IMG_H(8), .ACT_W(ACT_W), .CH(CH)) u_dut8 (
    .clk(clk), .rstn(rstn), .start_i(start), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready), .win_valid_o(win_valid), .win_data_o(win_data),
    .conv_ready_i(conv_ready), .busy_o(busy), .frame_done_o(frame_done), .out_count_o(out_count));

  conv_window_sched #(.IMG_W(4), .IMG_H(4), .ACT_W(ACT_W), .CH(CH)) u_dut4 (
    .clk(clk), .rstn(rstn), .start_i(s_start), .in_valid_i(s_in_valid), .in_data_i(s_in_data),
    .in_ready_o(s_in_ready), .win_valid_o(s_win_valid), .win_data_o(s_win_data),
    .conv_ready_i(s_cr_q), .busy_o(s_busy), .frame_done_o(s_frame_done), .out_count_o(s_out_count));

  // Datapath stand-in: one-cycle registered result strobe.
  always @(posedge clk or negedge rstn)
    if (!rstn) begin cr_q <= 1'b0; s_cr_q <= 1'b0; end
    else begin cr_q <= win_valid; s_cr_q <= s_win_valid; end

  function automatic logic [PW-1:0] pix(input int w, input int r, input int c);
    logic [PW-1:0] p;
    for (int k = 0; k < CH; k++) p[k*ACT_W +: ACT_W] = 16'(100*k + w*r + c);
    return p;
  endfunction

  // Window centred so that (r,c) is its newest (bottom-right) pixel.
  function automatic logic [WW-1:0] exp_win(input int w, input int r, input int c);
    logic [WW-1:0] e;
    for (int k = 0; k < CH; k++)
      for (int rr = 0; rr < 3; rr++)
        for (int cc = 0; cc < 3; cc++)
          e[(k*9 + 3*rr + cc)*ACT_W +: ACT_W] = 16'(100*k + w*(r-2+rr) + (c-2+cc));
    return e;
  endfunction

  task automatic check(input string name, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // 8x8 per-cycle model: position of every accepted beat decides win_valid/win_data next cycle.
  int m_n = 0;
  int win8_cnt = 0;
  int done8_cnt = 0;
  logic [WW-1:0] first_win8 = '0;
  always @(posedge clk) begin
    int pr, pc;
    logic acc, exp_wv;
    if (!rstn) m_n = 0;
    acc = rstn && in_valid && in_ready;
    pr = m_n / 8;
    pc = m_n % 8;
    exp_wv = acc && (pr >= 2) && (pc >= 2);
    if (acc) m_n = (m_n + 1) % 64;
    #1;
    check("win_valid8", WW'(win_valid), WW'(exp_wv));
    if (exp_wv) begin
      check("win_data8", win_data, exp_win(8, pr, pc));
      if (pr == 2 && pc == 2) first_win8 = win_data;
      win8_cnt++;
    end
    if (frame_done) done8_cnt++;
  end

  // 4x4 monitor
  int cyc = 0;
  int s_wins = 0, s_crs = 0, s_last_cr_t = -1, s_done_t = -1;
  logic [WW-1:0] s_first = '0;
  always @(posedge clk) begin
    cyc++;
    #1;
    if (s_win_valid) begin
      if (s_wins == 0) s_first = s_win_data;
      s_wins++;
    end
    if (s_cr_q) begin s_crs++; s_last_cr_t = cyc; end
    if (s_frame_done && s_done_t < 0) s_done_t = cyc;
  end

  task automatic run_frame(input bit gaps, input int abort_after, input bit poke_start);
    int n, budget;
    logic acc;
    @(negedge clk);
    start = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("out_count_restart", WW'(out_count), WW'(0));
    check("busy_run", WW'(busy), WW'(1));
    n = 0;
    budget = 0;
    while (n < 64 && n < abort_after && budget < 2000) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = pix(8, n / 8, n % 8) ^ {PW{~in_valid}};
      start    = poke_start && (n == 5 || n == 40);
      @(posedge clk);
      acc = in_valid && in_ready;
      @(negedge clk);
      if (acc) n++;
      budget++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (budget >= 2000) check("accept_timeout", WW'(n), WW'(64));
    if (abort_after >= 64) begin
      if (poke_start) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      budget = 0;
      while (!frame_done && budget < 100) begin
        @(negedge clk);
        budget++;
      end
      check("frame_done8", WW'(frame_done), WW'(1));
      check("out_count_done8", WW'(out_count), WW'(36));
      check("busy_done8", WW'(busy), WW'(0));
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n, budget;
    int lit0 [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    int lit8 [9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
    logic acc;
    rstn = 1'b0;
    start = 0; in_valid = 0; in_data = '0; cr_inj = 0;
    s_start = 0; s_in_valid = 0; s_in_data = '0;
    #12;
    check("rst_in_ready", WW'(in_ready), WW'(0));
    check("rst_win_valid", WW'(win_valid), WW'(0));
    check("rst_busy", WW'(busy), WW'(0));
    check("rst_frame_done", WW'(frame_done), WW'(0));
    check("rst_out_count", WW'(out_count), WW'(0));
    check("rst_win_data", win_data, WW'(0));
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // conv_ready while idle
    cr_inj = 1'b1;
    @(negedge clk);
    cr_inj = 1'b0;
    @(negedge clk);
    check("idle_conv_ready", WW'(out_count), WW'(0));

    // 4x4 smoke, continuous input
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    n = 0;
    budget = 0;
    while (n < 16 && budget < 200) begin
      s_in_valid = 1'b1;
      s_in_data  = pix(4, n / 4, n % 4);
      @(posedge clk);
      acc = s_in_valid && s_in_ready;
      @(negedge clk);
      if (acc) n++;
      budget++;
    end
    s_in_valid = 1'b0;
    budget = 0;
    while (!s_frame_done && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("smoke_frame_done", WW'(s_frame_done), WW'(1));
    check("smoke_out_count", WW'(s_out_count), WW'(4));
    check("smoke_windows", WW'(s_wins), WW'(4));
    check("smoke_results", WW'(s_crs), WW'(4));
    check("smoke_done_after_last_result", WW'(s_done_t), WW'(s_last_cr_t + 1));
    for (int t = 0; t < 9; t++)
      check("smoke_first_ch0", WW'(s_first[t*ACT_W +: ACT_W]), WW'(lit0[t]));
    check("smoke_first_ch2_t8", WW'(s_first[(18+8)*ACT_W +: ACT_W]), WW'(210));
    @(negedge clk);
    check("smoke_done_pulse", WW'(s_frame_done), WW'(0));

    // 8x8: gap-free with start pokes in RUN/DRAIN, then back-to-back gapped frame
    run_frame(1'b0, 64, 1'b1);
    run_frame(1'b1, 64, 1'b0);
    check("win8_count_2frames", WW'(win8_cnt), WW'(72));
    for (int t = 0; t < 9; t++)
      check("first8_ch0", WW'(first_win8[t*ACT_W +: ACT_W]), WW'(lit8[t]));
    check("first8_ch1_t4", WW'(first_win8[(9+4)*ACT_W +: ACT_W]), WW'(109));

    @(negedge clk);
    cr_inj = 1'b1;
    @(negedge clk);
    cr_inj = 1'b0;
    @(negedge clk);
    check("idle_conv_ready_hold", WW'(out_count), WW'(36));

    // Mid-frame reset after 10 accepts
    run_frame(1'b0, 10, 1'b0);
    rstn = 1'b0;
    #1;
    check("mid_rst_in_ready", WW'(in_ready), WW'(0));
    check("mid_rst_busy", WW'(busy), WW'(0));
    check("mid_rst_out_count", WW'(out_count), WW'(0));
    check("mid_rst_win_valid", WW'(win_valid), WW'(0));
    check("mid_rst_win_data", win_data, WW'(0));
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    run_frame(1'b1, 64, 1'b0);
    check("win8_count_total", WW'(win8_cnt), WW'(108));
    @(negedge clk);
    check("done8_pulses", WW'(done8_cnt), WW'(3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
